// File: rtl/xadac_pkg.sv
// rtl/xadac_pkg.sv - shared types and constants for the xadac execute interface
package xadac_pkg;

   localparam int VecDataWidth = 128;
   localparam int VecElemWidth = 8;
   localparam int VecLenWidth  = 8;
   localparam int XLen         = 32;
   localparam int IdWidth      = 4;
   localparam int AddrWidth    = 5;
   localparam int NoElem       = VecDataWidth / VecElemWidth;

   localparam logic [6:0] OpcCustom0 = 7'b0001011;

   typedef enum logic [2:0] {
      VADD = 3'b000,
      VDOT = 3'b001,
      VSUM = 3'b010
   } VecOpT;

   typedef struct packed {
      logic [IdWidth-1:0]                 id;
      logic [31:0]                        instr;
      logic [1:0][AddrWidth-1:0]          rs_addr;
      logic [1:0][XLen-1:0]               rs_data;
      logic [2:0][AddrWidth-1:0]          vs_addr;
      logic [2:0][VecDataWidth-1:0]       vs_data;
   } ExeReqT;

   typedef struct packed {
      logic [IdWidth-1:0]      id;
      logic [AddrWidth-1:0]    rd_addr;
      logic [XLen-1:0]         rd_data;
      logic                    rd_write;
      logic [AddrWidth-1:0]    vd_addr;
      logic [VecDataWidth-1:0] vd_data;
      logic                    vd_write;
   } ExeRspT;

endpackage

// File: rtl/xadac_vec_lane.sv
// rtl/xadac_vec_lane.sv - one 8-bit vector element: add result or 32-bit reduction partial
module xadac_vec_lane
   import xadac_pkg::*;
(
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic [7:0]  old,
   input  logic        active,
   input  VecOpT       op,
   output logic [7:0]  vd,
   output logic [31:0] partial
);

   logic [31:0] a_sext;
   logic [31:0] b_sext;

   assign a_sext = {{24{a[7]}}, a};
   assign b_sext = {{24{b[7]}}, b};

   // Inactive elements keep the old destination value and contribute nothing
   always_comb begin
      vd      = old;
      partial = '0;
      if (active) begin
         case (op)
            VADD:    vd      = a + b;
            VDOT:    partial = a_sext * b_sext;
            VSUM:    partial = {24'b0, a};
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/xadac_vec_exe.sv
// rtl/xadac_vec_exe.sv - xadac execute responder running VADD/VDOT/VSUM over Lanes elements per cycle
module xadac_vec_exe
   import xadac_pkg::*;
#(
   parameter int Lanes = 4
)(
   input  logic   clk_i,
   input  logic   rst_i,
   input  ExeReqT exe_req_i,
   input  logic   exe_valid_i,
   output logic   exe_ready_o,
   output ExeRspT rsp_o,
   output logic   rsp_valid_o,
   input  logic   rsp_ready_i
);

   localparam int NSteps = NoElem / Lanes;
   localparam int StepW  = (NSteps > 1) ? $clog2(NSteps) : 1;
   localparam int SliceW = Lanes * VecElemWidth;

   if (Lanes < 1 || (NoElem % Lanes) != 0) begin : g_bad_lanes
      $error("xadac_vec_exe: Lanes must divide NoElem");
   end

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                  state_q, state_d;
   logic [StepW-1:0]        step_q;
   logic [IdWidth-1:0]      id_q;
   logic [AddrWidth-1:0]    addr_q;
   logic [XLen-1:0]         rs0_q;
   logic [VecDataWidth-1:0] vs0_q, vs1_q, vd_q;
   logic [31:0]             acc_q;
   VecOpT                   op_q;
   logic                    nop_q;
   logic [VecLenWidth-1:0]  vl_q;

   logic [2:0]              funct3;
   logic                    dec_valid;
   logic [VecLenWidth-1:0]  rs1_len, vl_d;
   logic                    last_step;

   assign funct3    = exe_req_i.instr[14:12];
   assign dec_valid = (exe_req_i.instr[6:0] == OpcCustom0) && (funct3 <= 3'd2);
   assign rs1_len   = exe_req_i.rs_data[1][VecLenWidth-1:0];
   assign vl_d      = (rs1_len > VecLenWidth'(NoElem)) ? VecLenWidth'(NoElem) : rs1_len;
   assign last_step = (step_q == StepW'(NSteps - 1));

   logic unused_req;
   assign unused_req = ^{exe_req_i.instr[31:15], exe_req_i.rs_addr, exe_req_i.vs_addr,
                         exe_req_i.rs_data[1][XLen-1:VecLenWidth]};

   logic [SliceW-1:0]       a_slice, b_slice, old_slice, vd_slice;
   logic [Lanes-1:0][31:0]  lane_part;
   logic [31:0]             step_sum;

   assign a_slice   = vs0_q[step_q*SliceW +: SliceW];
   assign b_slice   = vs1_q[step_q*SliceW +: SliceW];
   assign old_slice = vd_q[step_q*SliceW +: SliceW];

   for (genvar j = 0; j < Lanes; j++) begin : g_lane
      logic active;
      assign active = !nop_q && ((int'(step_q) * Lanes + j) < int'(vl_q));
      xadac_vec_lane u_lane (
         .a       (a_slice[j*8 +: 8]),
         .b       (b_slice[j*8 +: 8]),
         .old     (old_slice[j*8 +: 8]),
         .active  (active),
         .op      (op_q),
         .vd      (vd_slice[j*8 +: 8]),
         .partial (lane_part[j])
      );
   end

   always_comb begin
      step_sum = '0;
      for (int j = 0; j < Lanes; j++) step_sum = step_sum + lane_part[j];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         step_q  <= '0;
         id_q    <= '0;
         addr_q  <= '0;
         rs0_q   <= '0;
         vs0_q   <= '0;
         vs1_q   <= '0;
         vd_q    <= '0;
         acc_q   <= '0;
         op_q    <= VADD;
         nop_q   <= 1'b1;
         vl_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && exe_valid_i) begin
            id_q   <= exe_req_i.id;
            addr_q <= exe_req_i.instr[11:7];
            rs0_q  <= exe_req_i.rs_data[0];
            vs0_q  <= exe_req_i.vs_data[0];
            vs1_q  <= exe_req_i.vs_data[1];
            vd_q   <= exe_req_i.vs_data[2];
            acc_q  <= '0;
            op_q   <= dec_valid ? VecOpT'(funct3) : VADD;
            nop_q  <= !dec_valid;
            vl_q   <= vl_d;
            step_q <= '0;
         end else if (state_q == BUSY) begin
            acc_q                           <= acc_q + step_sum;
            vd_q[step_q*SliceW +: SliceW]   <= vd_slice;
            step_q                          <= last_step ? '0 : step_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      exe_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      rsp_o       = '0;
      case (state_q)
         IDLE: begin
            exe_ready_o = 1'b1;
            if (exe_valid_i) state_d = BUSY;
         end
         BUSY: begin
            if (last_step) state_d = RESP;
         end
         RESP: begin
            rsp_valid_o    = 1'b1;
            rsp_o.id       = id_q;
            rsp_o.rd_addr  = addr_q;
            rsp_o.vd_addr  = addr_q;
            rsp_o.rd_write = !nop_q && (op_q != VADD);
            rsp_o.vd_write = !nop_q && (op_q == VADD);
            rsp_o.rd_data  = rsp_o.rd_write ? rs0_q + acc_q : '0;
            rsp_o.vd_data  = rsp_o.vd_write ? vd_q : '0;
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_xadac_vec_exe.sv
// tb/tb_xadac_vec_exe.sv - scoreboard bench for xadac_vec_exe
module tb_xadac_vec_exe;
   import xadac_pkg::*;

   logic   clk = 1'b0;
   logic   rst_i;
   ExeReqT exe_req;
   logic   exe_valid;
   logic   exe_ready;
   ExeRspT rsp;
   logic   rsp_valid;
   logic   rsp_ready;

   int n_cmp = 0;
   int n_err = 0;
   ExeRspT sb[$];

   always #5 clk = ~clk;

   xadac_vec_exe #(.Lanes(4)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .exe_req_i   (exe_req),
      .exe_valid_i (exe_valid),
      .exe_ready_o (exe_ready),
      .rsp_o       (rsp),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic ExeReqT mk(input logic [3:0] id, input logic [6:0] opc, input logic [2:0] f3,
                                 input logic [4:0] rd, input logic [31:0] rs0, input logic [31:0] rs1,
                                 input logic [127:0] vs0, input logic [127:0] vs1, input logic [127:0] vs2);
      ExeReqT r;
      r = '0;
      r.id = id;
      r.instr = {17'h1ABCD, f3, rd, opc};
      r.rs_data[0] = rs0;
      r.rs_data[1] = rs1;
      r.vs_data[0] = vs0;
      r.vs_data[1] = vs1;
      r.vs_data[2] = vs2;
      return r;
   endfunction

   function automatic ExeRspT model(input ExeReqT r);
      ExeRspT e;
      int vl;
      logic [2:0] f3;
      logic [31:0] acc;
      byte sa, sb_;
      logic [7:0] a, b;
      e = '0;
      vl = (r.rs_data[1][7:0] > 8'd16) ? 16 : int'(r.rs_data[1][7:0]);
      f3 = r.instr[14:12];
      e.id = r.id;
      e.rd_addr = r.instr[11:7];
      e.vd_addr = r.instr[11:7];
      acc = r.rs_data[0];
      if (r.instr[6:0] == 7'b0001011 && f3 <= 3'd2) begin
         for (int i = 0; i < 16; i++) begin
            a = r.vs_data[0][i*8 +: 8];
            b = r.vs_data[1][i*8 +: 8];
            sa = a;
            sb_ = b;
            if (f3 == 3'd0)
               e.vd_data[i*8 +: 8] = (i < vl) ? 8'(a + b) : r.vs_data[2][i*8 +: 8];
            else if (i < vl && f3 == 3'd1)
               acc = acc + 32'(int'(sa) * int'(sb_));
            else if (i < vl)
               acc = acc + {24'b0, a};
         end
         if (f3 == 3'd0) e.vd_write = 1'b1;
         else begin
            e.rd_write = 1'b1;
            e.rd_data = acc;
         end
      end
      return e;
   endfunction

   task automatic compare(input string tag, input ExeRspT e);
      check({tag, ".id"}, rsp.id, e.id);
      check({tag, ".rd_addr"}, rsp.rd_addr, e.rd_addr);
      check({tag, ".rd_data"}, rsp.rd_data, e.rd_data);
      check({tag, ".rd_write"}, rsp.rd_write, e.rd_write);
      check({tag, ".vd_addr"}, rsp.vd_addr, e.vd_addr);
      check({tag, ".vd_data"}, rsp.vd_data, e.vd_data);
      check({tag, ".vd_write"}, rsp.vd_write, e.vd_write);
   endtask

   task automatic run(input string tag, input ExeReqT r, input int hold);
      ExeRspT e;
      int lat;
      rsp_ready = (hold == 0);
      @(negedge clk);
      check({tag, ".ready_idle"}, exe_ready, 1'b1);
      exe_req = r;
      exe_valid = 1'b1;
      sb.push_back(model(r));
      @(negedge clk);
      exe_valid = 1'b0;
      exe_req = ~r;
      check({tag, ".ready_busy"}, exe_ready, 1'b0);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".latency"}, lat, 5);
      e = sb.pop_front();
      compare(tag, e);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check({tag, ".bp_valid"}, rsp_valid, 1'b1);
         check({tag, ".bp_ready"}, exe_ready, 1'b0);
         check({tag, ".bp_rsp"}, rsp, e);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check({tag, ".done_valid"}, rsp_valid, 1'b0);
      check({tag, ".done_ready"}, exe_ready, 1'b1);
   endtask

   initial begin
      int seen;
      ExeReqT r;
      rst_i = 1'b1;
      exe_req = '0;
      exe_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst.ready", exe_ready, 1'b1);
      check("rst.valid", rsp_valid, 1'b0);
      check("rst.rsp", rsp, '0);
      rst_i = 1'b0;

      run("vadd_full", mk(4'h5, 7'h0B, 3'd0, 5'd7, 32'h0, 32'd16,
                          {16{8'hFF}}, {16{8'h02}}, {16{8'h33}}), 0);
      run("vadd_vl3", mk(4'h1, 7'h0B, 3'd0, 5'd3, 32'h0, 32'd3,
                         {16{8'h01}}, {16{8'h01}}, {16{8'hAA}}), 0);
      run("vdot_full", mk(4'h2, 7'h0B, 3'd1, 5'd9, 32'd10, 32'd16,
                          {16{8'h80}}, {16{8'h7F}}, {16{8'h00}}), 0);
      run("vsum_vl0", mk(4'h3, 7'h0B, 3'd2, 5'd4, 32'hDEADBEEF, 32'd0,
                         {16{8'h11}}, {16{8'h22}}, {16{8'h44}}), 0);
      run("bad_opc", mk(4'h4, 7'h33, 3'd0, 5'd5, 32'h1234, 32'd16,
                        {16{8'h11}}, {16{8'h22}}, {16{8'h44}}), 0);
      run("bad_f3", mk(4'h6, 7'h0B, 3'd5, 5'd6, 32'h1234, 32'd16,
                       {16{8'h11}}, {16{8'h22}}, {16{8'h44}}), 0);
      run("vsum_clamp", mk(4'h7, 7'h0B, 3'd2, 5'd8, 32'd1, 32'd200,
                           {16{8'hF0}}, {16{8'h00}}, {16{8'h00}}), 0);

      for (int t = 0; t < 6; t++) begin
         r = mk(4'($urandom), 7'h0B, 3'($urandom_range(0, 2)), 5'($urandom), $urandom,
                32'($urandom_range(0, 20)),
                {$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom});
         run("rand", r, 0);
      end

      run("backpressure", mk(4'h9, 7'h0B, 3'd1, 5'd2, 32'h5, 32'd9,
                             {4{32'h81FE7F03}}, {4{32'h02C0FF80}}, {16{8'h00}}), 10);

      // Reset two cycles into BUSY: the response must never appear
      @(negedge clk);
      exe_req = mk(4'hA, 7'h0B, 3'd0, 5'd1, 32'h0, 32'd16, {16{8'h01}}, {16{8'h01}}, '0);
      exe_valid = 1'b1;
      @(negedge clk);
      exe_valid = 1'b0;
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      check("abort.ready", exe_ready, 1'b1);
      check("abort.valid", rsp_valid, 1'b0);
      check("abort.rsp", rsp, '0);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      check("abort.no_rsp", seen, 0);

      run("after_abort", mk(4'hB, 7'h0B, 3'd2, 5'd31, 32'd100, 32'd5,
                            {16{8'h0A}}, '0, '0), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
